oddr_pair_serializer: RTL
=========================

# oddr_pair_serializer

Parallel-to-DDR serializer that sits directly upstream of the output DDR register. It accepts WIDTH-bit words over a valid/ready handshake and emits them two bits per clock on D1/D2, with a matching clock-enable, so the DDR cell drives one bit per clock edge. Back-to-back words are streamed with no idle gap, and an underrun indication is raised when the stream runs dry.

## Interface
- WIDTH, 8, word width in bits; must be even and at least 2.
- INIT, 1'b0, idle line level; driven on D1/D2 in reset and idle, and matches the DDR cell's INIT.
- C  input  1  clock, shared with the DDR cell.
- R  input  1  reset; synchronous, active-high.
- DIN  input  WIDTH  word to serialize; bit 0 is transmitted first.
- DIN_VALID  input  1  DIN holds a word.
- DIN_READY  output  1  block accepts DIN at this edge.
- D1  output  1  rising-edge bit to the DDR cell; registered.
- D2  output  1  falling-edge bit to the DDR cell; registered.
- CE_OUT  output  1  clock enable to the DDR cell; registered.
- BUSY  output  1  a word is being shifted out; registered.
- UNDERRUN  output  1  one-cycle pulse: stream ended with no next word available.

## Operation
- Two states:
  - IDLE: no word in progress.
  - SHIFT: a word is being sent. Internally a WIDTH-bit shift register plus a pair counter `cnt` of width max(1, clog2(WIDTH/2)), counting 0..WIDTH/2-1.
- A word is accepted when DIN_VALID & DIN_READY are both high at a rising edge of C.
- DIN_READY is combinational from state only, never from DIN_VALID.
  - High in IDLE.
  - High in SHIFT when cnt == WIDTH/2-1, the last pair of the current word.
  - Forced low while R is high.
- IDLE, word accepted:
  - Load the shift register.
  - Next cycle: D1=DIN[0], D2=DIN[1], CE_OUT=1, BUSY=1, cnt=0, state SHIFT.
- SHIFT, cnt < WIDTH/2-1:
  - Next D1/D2 = the next bit pair (bits 2i, 2i+1).
  - cnt+1. CE_OUT=1.
- SHIFT, cnt == WIDTH/2-1:
  - New word accepted: load it and output its bits [1:0] next cycle. cnt=0, stay in SHIFT. No gap.
  - No word: go to IDLE. Next cycle D1=D2=INIT, CE_OUT=1 (flushes the idle level into the DDR cell), BUSY=0, UNDERRUN=1 for that single cycle.
- IDLE, no word:
  - D1=D2=INIT, CE_OUT=0 after the flush cycle, UNDERRUN=0.
- WIDTH=2: every SHIFT cycle is a last-pair cycle, so DIN_READY stays high continuously.
- Reset (R high at an edge, from any state, including mid-word):
  - State IDLE, cnt=0, shift register cleared.
  - D1=D2=INIT, CE_OUT=0, BUSY=0, UNDERRUN=0.
  - The in-flight word is discarded and is not resumed.
  - A DIN_VALID presented during reset is not accepted.

## Timing
- Latency: a word accepted at edge k has bits [1:0] on D1/D2 from edge k+1, and bits [2i+1:2i] from edge k+1+i.
- Last pair of a word appears at edge k+WIDTH/2.
- Throughput: one word per WIDTH/2 clocks when DIN_VALID is held high.
- All outputs except DIN_READY change only on rising edges of C.
- DIN_READY settles within the cycle from registered state.
- First edge after R deasserts: DIN_READY=1 and a word can be accepted.
- UNDERRUN is never asserted from IDLE and never after reset alone.

## Test plan
- Single word, WIDTH=8, DIN=0xB4 accepted at edge k:
  - D1/D2 = 0/0, 1/0, 1/1, 0/1 at edges k+1..k+4.
  - Then D1=D2=0 with CE_OUT=1 and UNDERRUN=1 at k+5.
  - CE_OUT=0 and UNDERRUN=0 at k+6.
- Back-to-back, WIDTH=8: 0xFF then 0x00 with DIN_VALID held high.
  - DIN_READY high at k and k+4.
  - D1=D2=1 at k+1..k+4, D1=D2=0 at k+5..k+8.
  - CE_OUT stays 1 and BUSY stays 1 through k+8; no UNDERRUN until k+9.
- Stall: DIN_VALID high while in SHIFT with cnt<3.
  - DIN_READY=0 and DIN is not consumed.
  - Changing DIN mid-word does not alter D1/D2.
- Reset mid-word: R high at edge k+2 of word 0xB4.
  - At k+3: D1=D2=INIT, CE_OUT=0, BUSY=0, UNDERRUN=0.
  - After R drops, a new word 0x5A produces 0/1, 0/1, 1/0, 1/0.
- INIT=1, WIDTH=2, stream 0b01, 0b10, then stop.
  - D1/D2 = 1/0, 0/1.
  - Then 1/1 with UNDERRUN=1 and CE_OUT=1.
  - DIN_READY never drops while streaming.
- Reset hold: R high for 3 cycles with DIN_VALID=1.
  - DIN_READY=0 and D1=D2=INIT throughout.
  - No word is emitted after release until a new handshake.

Source files
------------

// File: rtl/oddr_pair_serializer_if.sv
// Word-in / DDR-pair-out bundle for oddr_pair_serializer.
// The slave modport is the serializer side. The master modport is the producer/observer side.
interface oddr_pair_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DIN;
  logic             DIN_VALID;
  logic             DIN_READY;
  logic             D1;
  logic             D2;
  logic             CE_OUT;
  logic             BUSY;
  logic             UNDERRUN;

  modport slave (
    input  DIN, DIN_VALID,
    output DIN_READY, D1, D2, CE_OUT, BUSY, UNDERRUN
  );

  modport master (
    output DIN, DIN_VALID,
    input  DIN_READY, D1, D2, CE_OUT, BUSY, UNDERRUN
  );
endinterface

// File: rtl/oddr_pair_serializer.sv
// Parallel-to-DDR serializer: each WIDTH-bit word leaves as bit pairs on D1/D2, LSB pair first.
// Back-to-back words stream with no gap. An empty stream flushes INIT into the DDR cell and pulses UNDERRUN.
module oddr_pair_serializer #(
  parameter int   WIDTH = 8,     // must be even and >= 2
  parameter logic INIT  = 1'b0
) (
  input  logic                   C,
  input  logic                   R,
  oddr_pair_serializer_if.slave  bus
);
  localparam int PAIRS = WIDTH / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             d1, d2, ce, busy, underrun;
  logic             last_pair, accept;

  // Ready depends on state only. This lets the producer see it before it commits DIN_VALID.
  assign last_pair     = (cnt == LAST);
  assign bus.DIN_READY = !R && ((state == IDLE) || last_pair);
  assign accept        = bus.DIN_VALID && bus.DIN_READY;

  always_ff @(posedge C) begin
    if (R) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      d1       <= INIT;
      d2       <= INIT;
      ce       <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (accept) begin
        // Pair 0 goes straight to the outputs. sr keeps only the remaining pairs.
        sr    <= bus.DIN >> 2;
        d1    <= bus.DIN[0];
        d2    <= bus.DIN[1];
        ce    <= 1'b1;
        busy  <= 1'b1;
        cnt   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        if (last_pair) begin
          // Stream ran dry: one CE cycle pushes the idle level into the DDR cell.
          state    <= IDLE;
          cnt      <= '0;
          sr       <= '0;
          d1       <= INIT;
          d2       <= INIT;
          ce       <= 1'b1;
          busy     <= 1'b0;
          underrun <= 1'b1;
        end else begin
          d1  <= sr[0];
          d2  <= sr[1];
          sr  <= sr >> 2;
          cnt <= cnt + CW'(1);
          ce  <= 1'b1;
        end
      end else begin
        d1   <= INIT;
        d2   <= INIT;
        ce   <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

  assign bus.D1       = d1;
  assign bus.D2       = d2;
  assign bus.CE_OUT   = ce;
  assign bus.BUSY     = busy;
  assign bus.UNDERRUN = underrun;
endmodule
